// File: rtl/rom_dump_uart.sv
// Streams a range of HACK ROM words out over an 8N1 serial line, high byte first,
// pausing between frames while the receiver reports full. Optional: ROM_DUMP_CHECKSUM_EN.
module rom_dump_uart #(
   parameter int CLK_RATE = 50000000,
   parameter int BAUD     = 500000,
   parameter int ADDR_W   = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [15:0]       word_count,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_rd_en,
   input  logic [15:0]       rom_data,
   output logic              tx,
   input  logic              tx_hold,
   output logic              busy,
   output logic              done
);
   localparam int CLKS_PER_BIT = CLK_RATE / BAUD;
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef ROM_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, RD, CAP, CTS, SEND, NEXT, CHK, FIN} state_t;
`else
   typedef enum logic [2:0] {IDLE, RD, CAP, CTS, SEND, NEXT, FIN} state_t;
`endif

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [15:0]         count_reg;
   logic [15:0]         word_reg;
   logic                byte_sel_reg;
   logic [9:0]          shift_reg;
   logic [BAUD_W-1:0]   baud_cnt_reg;
   logic [3:0]          bit_cnt_reg;
   logic                hold_meta_reg, hold_s_reg;
   logic [7:0]          tx_byte;
   logic                bit_end, frame_end;
`ifdef ROM_DUMP_CHECKSUM_EN
   logic [7:0]          sum_reg;
   logic                chk_phase_reg;
`endif

   assign rom_addr  = addr_reg;
   assign bit_end   = (baud_cnt_reg == BAUD_LAST);
   assign frame_end = bit_end && (bit_cnt_reg == 4'd9);

`ifdef ROM_DUMP_CHECKSUM_EN
   assign tx_byte = chk_phase_reg ? sum_reg : (byte_sel_reg ? word_reg[7:0] : word_reg[15:8]);
`else
   assign tx_byte = byte_sel_reg ? word_reg[7:0] : word_reg[15:8];
`endif

   // The CTS cycle that sees the line clear already drives the start bit, so SEND
   // only covers the remaining CLKS_PER_BIT-1 cycles of it.
   always_comb begin
      state_next = state_reg;
      tx         = 1'b1;
      rom_rd_en  = 1'b0;
      done       = 1'b0;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE: if (start) begin
`ifdef ROM_DUMP_CHECKSUM_EN
            state_next = (word_count == 16'd0) ? CHK : RD;
`else
            state_next = (word_count == 16'd0) ? FIN : RD;
`endif
         end
         RD: begin
            rom_rd_en  = 1'b1;
            state_next = CAP;
         end
         CAP: state_next = CTS;
         CTS: if (!hold_s_reg) begin
            tx         = 1'b0;
            state_next = SEND;
         end
         SEND: begin
            tx = shift_reg[0];
            if (frame_end) begin
`ifdef ROM_DUMP_CHECKSUM_EN
               if (chk_phase_reg)
                  state_next = FIN;
               else
`endif
               state_next = byte_sel_reg ? NEXT : CTS;
            end
         end
         NEXT: begin
`ifdef ROM_DUMP_CHECKSUM_EN
            state_next = (count_reg == 16'd1) ? CHK : RD;
`else
            state_next = (count_reg == 16'd1) ? FIN : RD;
`endif
         end
`ifdef ROM_DUMP_CHECKSUM_EN
         CHK: state_next = CTS;
`endif
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         count_reg     <= '0;
         word_reg      <= '0;
         byte_sel_reg  <= 1'b0;
         shift_reg     <= '1;
         baud_cnt_reg  <= '0;
         bit_cnt_reg   <= '0;
         hold_meta_reg <= 1'b0;
         hold_s_reg    <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
         sum_reg       <= '0;
         chk_phase_reg <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         hold_meta_reg <= tx_hold;
         hold_s_reg    <= hold_meta_reg;
         case (state_reg)
            IDLE: if (start) begin
               addr_reg     <= start_addr;
               count_reg    <= word_count;
               byte_sel_reg <= 1'b0;
`ifdef ROM_DUMP_CHECKSUM_EN
               sum_reg       <= '0;
               chk_phase_reg <= 1'b0;
`endif
            end
            CAP: begin
               word_reg     <= rom_data;
               byte_sel_reg <= 1'b0;
            end
            CTS: if (!hold_s_reg) begin
               shift_reg    <= {1'b1, tx_byte, 1'b0};
               baud_cnt_reg <= BAUD_W'(1);
               bit_cnt_reg  <= '0;
`ifdef ROM_DUMP_CHECKSUM_EN
               if (!chk_phase_reg)
                  sum_reg <= sum_reg + tx_byte;
`endif
            end
            SEND: begin
               if (bit_end) begin
                  baud_cnt_reg <= '0;
                  shift_reg    <= {1'b1, shift_reg[9:1]};
                  bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                  if (bit_cnt_reg == 4'd9)
                     byte_sel_reg <= 1'b1;
               end else begin
                  baud_cnt_reg <= baud_cnt_reg + BAUD_W'(1);
               end
            end
            NEXT: begin
               count_reg <= count_reg - 16'd1;
               addr_reg  <= addr_reg + ADDR_W'(1);
            end
`ifdef ROM_DUMP_CHECKSUM_EN
            CHK: chk_phase_reg <= 1'b1;
`endif
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_rom_dump_uart.sv
// Directed bench for rom_dump_uart at 4 clocks per bit; decodes tx frames and checks
// cycle timing, read addresses, flow control and reset. Honours ROM_DUMP_CHECKSUM_EN.
module tb_rom_dump_uart;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [14:0] start_addr;
   logic [15:0] word_count;
   logic [14:0] rom_addr;
   logic        rom_rd_en;
   logic [15:0] rom_data;
   logic        tx;
   logic        tx_hold;
   logic        busy;
   logic        done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cyc_start = 0;
   logic [15:0] rom [0:32767];
   logic [14:0] rd_q[$];

   rom_dump_uart #(.CLK_RATE(2000000), .BAUD(500000), .ADDR_W(15)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .word_count(word_count), .rom_addr(rom_addr), .rom_rd_en(rom_rd_en),
      .rom_data(rom_data), .tx(tx), .tx_hold(tx_hold), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (rom_rd_en) begin
      rom_data <= rom[rom_addr];
      rd_q.push_back(rom_addr);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic [14:0] a, input logic [15:0] n);
      @(posedge clk); #1;
      start = 1'b1; start_addr = a; word_count = n;
      cyc_start = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] b, output int start_rel);
      int n;
      logic [7:0] got;
      logic sb, pb;
      n = 0;
      @(negedge clk);
      while (tx !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (tx !== 1'b0) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
         start_rel = -1;
         return;
      end
      start_rel = cyc - cyc_start;
      repeat (2) @(negedge clk);
      sb = tx;
      for (int k = 0; k < 8; k++) begin
         repeat (4) @(negedge clk);
         got[k] = tx;
      end
      repeat (4) @(negedge clk);
      pb = tx;
      $display("frame %s byte=%02h start_cycle=%0d", tag, got, start_rel);
      check({tag, "_byte"}, {24'd0, got}, {24'd0, b});
      check({tag, "_framing"}, {30'd0, sb, pb}, 32'd1);
   endtask

   task automatic wait_done(input string tag, input int exp_rel);
      int n, lows;
      n = 0;
      lows = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 2000) begin
         if (tx !== 1'b1) lows++;
         @(negedge clk);
         n++;
      end
      $display("done %s cycle=%0d", tag, cyc - cyc_start);
      check({tag, "_done_at"}, cyc - cyc_start, exp_rel);
      check({tag, "_busy_fin"}, {31'd0, busy}, 32'd1);
      check({tag, "_tx_quiet"}, lows, 0);
      @(negedge clk);
      check({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int r, lows, dn, rds;
      rom[5] = 16'hA55A; rom[6] = 16'hC33C; rom[32767] = 16'hBEEF; rom[0] = 16'h1234;
      rom[10] = 16'h0102; rom[11] = 16'h0304;
      rst = 1'b1; start = 1'b0; start_addr = '0; word_count = '0; tx_hold = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {12'd0, tx, busy, done, rom_rd_en, rom_addr}, {12'd0, 4'b1000, 15'd0});
      @(posedge clk); #1 rst = 1'b0;

      // single word, latency and frame timing
      rd_q.delete();
      do_start(15'd5, 16'd1);
      @(negedge clk);
      check("t1_rd_cycle1", {15'd0, rom_rd_en, busy, rom_addr}, {15'd0, 2'b11, 15'd5});
      expect_frame("t1_hi", 8'hA5, r);
      check("t1_hi_start_cycle", r, 3);
      expect_frame("t1_lo", 8'h5A, r);
      check("t1_lo_start_cycle", r, 43);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t1_sum", 8'hFF, r);
      wait_done("t1", 125);
`else
      wait_done("t1", 84);
`endif
      check("t1_reads", rd_q.size(), 1);

      // zero-length dump
      rd_q.delete();
      do_start(15'd5, 16'd0);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t2_sum", 8'h00, r);
      wait_done("t2", 42);
`else
      wait_done("t2", 1);
`endif
      check("t2_no_reads", rd_q.size(), 0);

      // address wrap, plus a start pulse while busy that must be ignored
      rd_q.delete();
      do_start(15'h7FFF, 16'd2);
      @(negedge clk);
      check("t3_rd_cycle1", {16'd0, rom_rd_en, rom_addr}, {16'd0, 1'b1, 15'h7FFF});
      start = 1'b1; start_addr = 15'h0123; word_count = 16'd5;
      @(posedge clk); #1 start = 1'b0;
      expect_frame("t3_b0", 8'hBE, r);
      expect_frame("t3_b1", 8'hEF, r);
      expect_frame("t3_b2", 8'h12, r);
      check("t3_b2_start_cycle", r, 86);
      expect_frame("t3_b3", 8'h34, r);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t3_sum", 8'hF3, r);
      wait_done("t3", 208);
`else
      wait_done("t3", 167);
`endif
      check("t3_read_count", rd_q.size(), 2);
      if (rd_q.size() == 2) begin
         check("t3_read0", {17'd0, rd_q[0]}, 32'h7FFF);
         check("t3_read1", {17'd0, rd_q[1]}, 32'h0000);
      end

      // flow control: hold raised mid-frame, released at cycle 61
      do_start(15'd5, 16'd2);
      fork
         begin
            repeat (12) @(posedge clk);
            #1 tx_hold = 1'b1;
         end
      join_none
      expect_frame("t4_b0", 8'hA5, r);
      check("t4_b0_start_cycle", r, 3);
      lows = 0;
      while (cyc - cyc_start < 60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      @(posedge clk); #1 tx_hold = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("t4_held_idle", lows, 0);
      expect_frame("t4_b1", 8'h5A, r);
      check("t4_b1_start_cycle", r, 63);
      expect_frame("t4_b2", 8'hC3, r);
      expect_frame("t4_b3", 8'h3C, r);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t4_sum", 8'hFE, r);
      wait_done("t4", 228);
`else
      wait_done("t4", 187);
`endif

      // reset in the middle of a frame, then a clean dump
      do_start(15'd5, 16'd1);
      while (cyc - cyc_start < 20) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      check("t5_pre_rst_tx", {31'd0, tx}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t5_after_rst", {30'd0, tx, busy}, 32'd2);
      dn = 0; lows = 0;
      rd_q.delete();
      repeat (10) begin
         @(negedge clk);
         if (done !== 1'b0) dn++;
         if (tx !== 1'b1) lows++;
      end
      check("t5_no_done", dn, 0);
      check("t5_quiet", lows + rd_q.size(), 0);
      do_start(15'd0, 16'd1);
      expect_frame("t5_hi", 8'h12, r);
      check("t5_hi_start_cycle", r, 3);
      expect_frame("t5_lo", 8'h34, r);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t5_sum", 8'h46, r);
      wait_done("t5", 125);
`else
      wait_done("t5", 84);
`endif

      // two-word dump used for the checksum case
      rd_q.delete();
      do_start(15'd10, 16'd2);
      expect_frame("t6_b0", 8'h01, r);
      expect_frame("t6_b1", 8'h02, r);
      expect_frame("t6_b2", 8'h03, r);
      expect_frame("t6_b3", 8'h04, r);
`ifdef ROM_DUMP_CHECKSUM_EN
      expect_frame("t6_sum", 8'h0A, r);
      wait_done("t6", 208);
`else
      wait_done("t6", 167);
`endif
      rds = rd_q.size();
      check("t6_read_count", rds, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
